// File: rtl/flag_pipe_if.sv
// Condition-flag interface between the E1/E2 pipeline control and the flag owner.
// The flag owner uses the slave modport; the surrounding pipeline uses master.
interface flag_pipe_if;
    logic       ValidE1;
    logic [3:0] CondE1;
    logic [1:0] FlagWriteE1;
    logic       LongOpE1;
    logic       StallE2;
    logic       FlushE2;
    logic [3:0] Flags;
    logic       CondExE2;
    logic [3:0] CondE2;
    logic [1:0] FlagWriteE2;
    logic [3:0] FlagsE2;
    logic       ValidE2;
    logic       BusyE2;

    modport slave (
        input  ValidE1, CondE1, FlagWriteE1, LongOpE1, StallE2, FlushE2, Flags, CondExE2,
        output CondE2, FlagWriteE2, FlagsE2, ValidE2, BusyE2
    );

    modport master (
        output ValidE1, CondE1, FlagWriteE1, LongOpE1, StallE2, FlushE2, Flags, CondExE2,
        input  CondE2, FlagWriteE2, FlagsE2, ValidE2, BusyE2
    );
endinterface

// File: rtl/flag_pipe.sv
// NZCV flag owner and E1->E2 pipeline register; holds E2 for long ops so the
// flag write of a multi-cycle instruction commits exactly once.
module flag_pipe #(
    parameter int LONG_CYCLES = 3
) (
    input logic        clk,
    input logic        reset,
    flag_pipe_if.slave bus
);
    localparam logic [3:0] COND_AL  = 4'b1110;
    localparam bit         HAS_LONG = (LONG_CYCLES > 1);
    localparam logic [3:0] LOAD_CNT = 4'(LONG_CYCLES - 1);

    typedef enum logic {IDLE, LONG} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       valid, valid_n;
    logic [3:0] cond, cond_n;
    logic [1:0] fw, fw_n;
    logic [3:0] flags, flags_n;
    logic       busy, hold, load, commit;

    assign busy   = (state == LONG);
    assign hold   = bus.StallE2 | busy;
    assign load   = ~hold;
    assign commit = valid & bus.CondExE2 & ~hold & ~(bus.FlushE2 & hold);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_n = state;
        cnt_n   = cnt;
        valid_n = valid;
        cond_n  = cond;
        fw_n    = fw;
        flags_n = flags;

        if (commit) flags_n = bus.Flags;

        // The hold countdown runs regardless of StallE2.
        if (state == LONG) begin
            cnt_n = cnt - 4'd1;
            if (cnt <= 4'd1) state_n = IDLE;
        end

        if (bus.FlushE2) begin
            valid_n = 1'b0;
            fw_n    = 2'b00;
            cond_n  = COND_AL;
            state_n = IDLE;
            cnt_n   = 4'd0;
        end else if (load) begin
            valid_n = bus.ValidE1;
            cond_n  = bus.CondE1;
            fw_n    = bus.FlagWriteE1 & {2{bus.ValidE1}};
            if (HAS_LONG && bus.ValidE1 && bus.LongOpE1) begin
                state_n = LONG;
                cnt_n   = LOAD_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            valid <= 1'b0;
            cond  <= COND_AL;
            fw    <= 2'b00;
            flags <= 4'b0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            valid <= valid_n;
            cond  <= cond_n;
            fw    <= fw_n;
            flags <= flags_n;
        end
    end

    assign bus.ValidE2     = valid;
    assign bus.CondE2      = cond;
    assign bus.FlagWriteE2 = fw & {2{valid}};
    assign bus.FlagsE2     = flags;
    assign bus.BusyE2      = busy;
endmodule

// File: tb/tb_flag_pipe.sv
// Directed bench for flag_pipe with LONG_CYCLES=3: reset, commit latency,
// long-op hold, flush/stall interactions.
module tb_flag_pipe;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    flag_pipe_if bus ();

    flag_pipe #(.LONG_CYCLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; registered outputs are stable then.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ValidE1     = 1'b0;
        bus.CondE1      = 4'hE;
        bus.FlagWriteE1 = 2'b00;
        bus.LongOpE1    = 1'b0;
        bus.StallE2     = 1'b0;
        bus.FlushE2     = 1'b0;
        bus.Flags       = 4'h0;
        bus.CondExE2    = 1'b0;
    endtask

    task automatic present(input logic [3:0] c, input logic [1:0] w, input logic lng);
        bus.ValidE1     = 1'b1;
        bus.CondE1      = c;
        bus.FlagWriteE1 = w;
        bus.LongOpE1    = lng;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", {3'b0, bus.ValidE2}, 4'h0);
        check("rst_cond",  bus.CondE2, 4'hE);
        check("rst_fw",    {2'b0, bus.FlagWriteE2}, 4'h0);
        check("rst_flags", bus.FlagsE2, 4'h0);
        check("rst_busy",  {3'b0, bus.BusyE2}, 4'h0);

        // ADDS then a dependent EQ instruction
        present(4'hE, 2'b11, 1'b0);
        tick();
        check("adds_valid", {3'b0, bus.ValidE2}, 4'h1);
        check("adds_fw",    {2'b0, bus.FlagWriteE2}, 4'h3);
        check("adds_noyet", bus.FlagsE2, 4'h0);
        present(4'h0, 2'b00, 1'b0);
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'b0110;
        tick();
        check("adds_flags", bus.FlagsE2, 4'b0110);
        check("eq_in_e2",   bus.CondE2, 4'h0);
        check("eq_sees_z",  {3'b0, bus.FlagsE2[2]}, 4'h1);
        bus.ValidE1 = 1'b0;
        tick();
        check("eq_retired", {3'b0, bus.ValidE2}, 4'h0);
        check("eq_keep",    bus.FlagsE2, 4'b0110);

        // Long op: busy for two cycles, one commit, held E1 instruction follows
        present(4'hE, 2'b10, 1'b1);
        bus.CondExE2 = 1'b0;
        tick();
        check("long_busy0",  {3'b0, bus.BusyE2}, 4'h1);
        check("long_valid",  {3'b0, bus.ValidE2}, 4'h1);
        check("long_fw",     {2'b0, bus.FlagWriteE2}, 4'h2);
        present(4'h1, 2'b01, 1'b0);
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'hF;
        tick();
        check("long_busy1",  {3'b0, bus.BusyE2}, 4'h1);
        check("long_nocm1",  bus.FlagsE2, 4'b0110);
        check("long_hold1",  bus.CondE2, 4'hE);
        tick();
        check("long_free",   {3'b0, bus.BusyE2}, 4'h0);
        check("long_nocm2",  bus.FlagsE2, 4'b0110);
        check("long_hold2",  bus.CondE2, 4'hE);
        check("long_vhold",  {3'b0, bus.ValidE2}, 4'h1);
        bus.Flags = 4'b1000;
        tick();
        check("long_commit", bus.FlagsE2, 4'b1000);
        check("next_cond",   bus.CondE2, 4'h1);
        check("next_fw",     {2'b0, bus.FlagWriteE2}, 4'h1);
        check("next_busy",   {3'b0, bus.BusyE2}, 4'h0);
        bus.ValidE1  = 1'b0;
        bus.CondExE2 = 1'b0;
        bus.Flags    = 4'h0;
        tick();
        check("ne_fail",     bus.FlagsE2, 4'b1000);
        check("ne_gone",     {3'b0, bus.ValidE2}, 4'h0);

        // Long op aborted by flush while busy
        do_reset();
        present(4'hE, 2'b11, 1'b1);
        tick();
        check("ab_busy",     {3'b0, bus.BusyE2}, 4'h1);
        idle_inputs();
        bus.FlushE2  = 1'b1;
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'hF;
        tick();
        check("ab_busyoff",  {3'b0, bus.BusyE2}, 4'h0);
        check("ab_valid",    {3'b0, bus.ValidE2}, 4'h0);
        check("ab_fw",       {2'b0, bus.FlagWriteE2}, 4'h0);
        check("ab_cond",     bus.CondE2, 4'hE);
        check("ab_flags",    bus.FlagsE2, 4'h0);
        bus.FlushE2 = 1'b0;
        tick();
        check("ab_flags2",   bus.FlagsE2, 4'h0);

        // Stall for 4 cycles then a single commit
        present(4'hE, 2'b11, 1'b0);
        bus.CondExE2 = 1'b0;
        tick();
        present(4'h2, 2'b00, 1'b0);
        bus.StallE2  = 1'b1;
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_nocm", bus.FlagsE2, 4'h0);
            check("stall_cond", bus.CondE2, 4'hE);
        end
        bus.StallE2 = 1'b0;
        tick();
        check("stall_commit", bus.FlagsE2, 4'b0001);
        check("stall_load",   bus.CondE2, 4'h2);
        bus.ValidE1  = 1'b0;
        bus.CondExE2 = 1'b0;
        bus.Flags    = 4'hF;
        tick();
        check("stall_once",   bus.FlagsE2, 4'b0001);

        // Flush with E2 not held: current commits, incoming squashed
        present(4'hE, 2'b11, 1'b0);
        tick();
        present(4'h3, 2'b11, 1'b0);
        bus.FlushE2  = 1'b1;
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'b0100;
        tick();
        check("fl_commit",   bus.FlagsE2, 4'b0100);
        check("fl_squash",   {3'b0, bus.ValidE2}, 4'h0);
        check("fl_cond",     bus.CondE2, 4'hE);
        present(4'hE, 2'b11, 1'b0);
        bus.FlushE2  = 1'b0;
        bus.CondExE2 = 1'b0;
        tick();
        present(4'h3, 2'b11, 1'b0);
        bus.FlushE2 = 1'b1;
        bus.Flags   = 4'hF;
        tick();
        check("fl_condfail", bus.FlagsE2, 4'b0100);
        check("fl_squash2",  {3'b0, bus.ValidE2}, 4'h0);

        // Flush while stalled squashes the held instruction without commit
        present(4'hE, 2'b11, 1'b0);
        bus.FlushE2 = 1'b0;
        tick();
        bus.ValidE1  = 1'b0;
        bus.StallE2  = 1'b1;
        bus.FlushE2  = 1'b1;
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'hF;
        tick();
        check("sf_nocommit", bus.FlagsE2, 4'b0100);
        check("sf_squash",   {3'b0, bus.ValidE2}, 4'h0);

        // Reset in the middle of a long op
        idle_inputs();
        present(4'h5, 2'b11, 1'b1);
        tick();
        check("rl_busy",     {3'b0, bus.BusyE2}, 4'h1);
        idle_inputs();
        bus.CondExE2 = 1'b1;
        bus.Flags    = 4'hF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rl_busyoff",  {3'b0, bus.BusyE2}, 4'h0);
        check("rl_valid",    {3'b0, bus.ValidE2}, 4'h0);
        check("rl_flags",    bus.FlagsE2, 4'h0);
        check("rl_cond",     bus.CondE2, 4'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flag_pipe.md
Name: flag_pipe

Overview:
- Producer/owner side of the condition-flag interface used by the E2 conditional-execution unit.
- Holds the architectural NZCV flags register and the E1→E2 pipeline register for Cond, FlagWrite and Valid, and drives them into E2 as CondE2, FlagWriteE2 and FlagsE2.
- Captures the conditional unit's updated Flags when the E2 instruction retires.
- Holds E2 for multi-cycle (long) operations so that their flag write commits only once.

Parameters:
- LONG_CYCLES, 3: total E2 occupancy in cycles for a long op. Legal range 1..16; 1 means no extra hold.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ValidE1  in  1  an instruction is presented by E1.
- CondE1  in  4  condition field of the E1 instruction.
- FlagWriteE1  in  2  flag-write enables: [1] writes N,Z; [0] writes C,V.
- LongOpE1  in  1  the E1 instruction is a multi-cycle op.
- StallE2  in  1  hazard unit holds E2.
- FlushE2  in  1  squash the instruction entering E2 (see rules below).
- Flags  in  4  next NZCV from the conditional unit, already merged per FlagWriteE2 and CondExE2.
- CondExE2  in  1  condition-pass result for the E2 instruction.
- CondE2  out  4  registered condition field.
- FlagWriteE2  out  2  registered flag-write enables, forced to 0 when ValidE2=0.
- FlagsE2  out  4  architectural NZCV as [3]N [2]Z [1]C [0]V.
- ValidE2  out  1  E2 holds a live instruction.
- BusyE2  out  1  long op in progress; upstream must hold E1.

Behaviour:
- Reset state: ValidE2=0, CondE2=4'b1110 (AL), FlagWriteE2=2'b00, FlagsE2=4'b0000, BusyE2=0, hold counter=0, FSM=IDLE.
  - Reset takes effect from any state and aborts a pending long op with no commit.
- FSM states: IDLE and LONG.
  - IDLE→LONG when a long op is loaded into E2 (ValidE1 & LongOpE1 & load) and LONG_CYCLES>1. The counter loads LONG_CYCLES-1.
  - In LONG, the counter decrements every cycle, independent of StallE2.
  - LONG→IDLE when the counter reaches 0, or on flush-abort.
  - BusyE2 = (FSM==LONG). This is a registered output, asserted the cycle after the load.
- Control terms:
  - hold = StallE2 | BusyE2
  - load = ~hold
- E2 register update:
  - If FlushE2: ValidE2←0, FlagWriteE2←0, CondE2←AL, FSM←IDLE, counter←0.
  - Else if load: ValidE2←ValidE1, CondE2←CondE1, FlagWriteE2←FlagWriteE1 & {2{ValidE1}}.
  - Else: all E2 fields are held.
- Flag commit:
  - commit = ValidE2 & CondExE2 & ~hold & ~(FlushE2 & hold).
  - On commit, FlagsE2←Flags the next cycle.
  - With no commit, FlagsE2 holds. The conditional unit already masks unwritten fields, so the whole 4-bit word is captured.
- Flush semantics:
  - When E2 is not held, the current E2 instruction still commits in the flush cycle; only the incoming E1 instruction is squashed.
  - When E2 is held (stall or busy), flush squashes the held instruction: no commit, and the long op is aborted.
- Single commit per instruction: a long op commits exactly once, in the first cycle where BusyE2=0 and StallE2=0.
- Simultaneous events:
  - FlushE2 beats StallE2 and beats load.
  - reset beats everything.
- Failed condition (CondExE2=0): no commit and the flags are unchanged. The long op still occupies E2 for LONG_CYCLES cycles.
- Latency: flags written by the instruction in E2 at cycle t are visible on FlagsE2 at t+1, for a back-to-back dependent instruction.

Test Plan:
- Reset, then check outputs → ValidE2=0, CondE2=E, FlagWriteE2=0, FlagsE2=0, BusyE2=0.
- E1: ADDS with Cond=E, FlagWrite=11, no stall; conditional unit returns Flags=4'b0110, CondExE2=1 → FlagsE2=0110 one cycle after the E2 cycle. A following EQ instruction sees Z=1.
- Long op with FlagWrite=10, LONG_CYCLES=3, Flags=4'b1000 → BusyE2 high for 2 cycles, ValidE2 held, exactly one commit, FlagsE2=1000. An E1 instruction held during busy enters E2 afterwards.
- Long op in E2 busy + FlushE2 pulse → BusyE2 falls the next cycle, ValidE2=0, FlagsE2 unchanged (0000).
- StallE2 held 4 cycles with valid E2 ADDS, Flags=0001 → no commit while stalled, single commit after release, FlagsE2=0001.
- FlushE2 with E2 unheld, CondExE2=1, Flags=0100 → FlagsE2=0100 (current instruction commits), incoming instruction squashed (ValidE2=0). Repeating with CondExE2=0 → FlagsE2 unchanged.
